// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: multi-cycle shift-add multiplier and restoring divider, plus MTHI/MTLO.
// HI/LO change only on FIX or on the MTHI/MTLO edge; operands are held as magnitudes plus signs.
module hilo_muldiv_unit #(
  parameter logic [31:0] HI_INIT = 32'h0000_0000,
  parameter logic [31:0] LO_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_q;
  logic        neg_r;
  logic        zero_flag;

  logic [63:0] acc;
  logic [63:0] opa;
  logic [31:0] opb;

  logic        signed_op;
  logic        launch_long;
  logic [32:0] shifted;
  logic [32:0] diff;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    logic signed [31:0] sx;
    sx = x;
    return (sgn && sx < 0) ? 32'(-sx) : x;
  endfunction

  function automatic logic [31:0] cneg32(input logic [31:0] x, input logic neg);
    logic signed [31:0] sx;
    sx = x;
    return neg ? 32'(-sx) : x;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] x, input logic neg);
    logic signed [63:0] sx;
    sx = x;
    return neg ? 64'(-sx) : x;
  endfunction

  assign signed_op   = (op == OP_MULT) || (op == OP_DIV);
  assign launch_long = start && ((op == OP_MULT) || (op == OP_MULTU) ||
                                 (((op == OP_DIV) || (op == OP_DIVU)) && (rt_val != 32'd0)));

  // Restoring-divide trial: remainder lives in acc[63:32], dividend/quotient in acc[31:0].
  assign shifted = {acc[63:32], acc[31]};
  assign diff    = shifted - {1'b0, opb};

  // Datapath registers: no reset, meaningful only while an operation is in flight.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (launch_long) begin
        opa <= {32'd0, mag32(rs_val, signed_op)};
        opb <= mag32(rt_val, signed_op);
        acc <= ((op == OP_MULT) || (op == OP_MULTU)) ? 64'd0
                                                      : {32'd0, mag32(rs_val, signed_op)};
      end
      S_MUL: begin
        acc <= acc + (opb[0] ? opa : 64'd0);
        opa <= opa << 1;
        opb <= opb >> 1;
      end
      S_DIV: begin
        if (!diff[32]) acc <= {diff[31:0], acc[30:0], 1'b1};
        else           acc <= {shifted[31:0], acc[30:0], 1'b0};
      end
      default: ;
    endcase
  end

  // Control FSM and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 5'd0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= HI_INIT;
      lo        <= LO_INIT;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          case (op)
            OP_MTHI: begin
              hi   <= rs_val;
              done <= 1'b1;
            end
            OP_MTLO: begin
              lo   <= rs_val;
              done <= 1'b1;
            end
            OP_MULT, OP_MULTU: begin
              state     <= S_MUL;
              busy      <= 1'b1;
              cnt       <= 5'd0;
              is_div    <= 1'b0;
              neg_q     <= signed_op && (rs_val[31] ^ rt_val[31]);
              neg_r     <= 1'b0;
              zero_flag <= 1'b0;
            end
            OP_DIV, OP_DIVU: begin
              state     <= (rt_val == 32'd0) ? S_FIX : S_DIV;
              busy      <= 1'b1;
              cnt       <= 5'd0;
              is_div    <= 1'b1;
              neg_q     <= signed_op && (rs_val[31] ^ rt_val[31]);
              neg_r     <= signed_op && rs_val[31];
              zero_flag <= (rt_val == 32'd0);
            end
            default: ;
          endcase
        end
        S_MUL, S_DIV: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (zero_flag) begin
            div_zero <= 1'b1;
          end else if (is_div) begin
            lo <= cneg32(acc[31:0], neg_q);
            hi <= cneg32(acc[63:32], neg_r);
          end else begin
            {hi, lo} <= cneg64(acc, neg_q);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: MTHI/MTLO, MULT/MULTU, DIV/DIVU, divide-by-zero,
// dropped starts, mid-operation reset and back-to-back launches.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] mhi;
  logic [31:0] mlo;

  hilo_muldiv_unit #(.HI_INIT(32'h0), .LO_INIT(32'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic drive_start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 3'b000; rs_val = 32'd0; rt_val = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({hi, lo} !== 64'd0 || {busy, done, div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b dz=%b, want all zero",
               hi, lo, busy, done, div_zero);
    end
    drive_start(OP_MTHI, 32'hAAAA5555, 32'd0);
    drive_start(OP_MTLO, 32'h5555AAAA, 32'd0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({hi, lo} !== 64'd0 || {busy, done, div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL async_reset: hi=%h lo=%h busy=%b done=%b dz=%b, want all zero",
               hi, lo, busy, done, div_zero);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    mhi = 32'd0; mlo = 32'd0;
  endtask

  task automatic test_mthi_mtlo();
    drive_start(OP_MTHI, 32'h12345678, 32'd0);
    checks++;
    if (hi !== 32'h12345678 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi: hi=%h done=%b busy=%b, want 12345678 1 0", hi, done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mthi_pulse: done=%b busy=%b, want 0 0", done, busy);
    end
    drive_start(OP_MTLO, 32'h87654321, 32'd0);
    checks++;
    if (lo !== 32'h87654321 || hi !== 32'h12345678 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mtlo: hi=%h lo=%h done=%b busy=%b, want 12345678 87654321 1 0",
               hi, lo, done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo_pulse: done=%b, want 0", done);
    end
    mhi = 32'h12345678; mlo = 32'h87654321;
  endtask

  task automatic test_long_ops(input string tag, input logic [2:0] ops [3],
                               input logic [31:0] av [3], input logic [31:0] bv [3],
                               input logic [31:0] eh [3], input logic [31:0] el [3], input int n);
    int bad_e;
    for (int i = 0; i < n; i++) begin
      drive_start(ops[i], av[i], bv[i]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s%0d_busy_rise: busy=%b done=%b, want 1 0", tag, i, busy, done);
      end
      bad_e = 0;
      for (int e = 1; e <= 32; e++) begin
        @(posedge clk); #1;
        if (bad_e == 0 && (hi !== mhi || lo !== mlo || done !== 1'b0 || busy !== 1'b1))
          bad_e = e;
      end
      checks++;
      if (bad_e != 0) begin
        failures++;
        $display("FAIL %s%0d_hold: first bad edge E%0d, hi=%h lo=%h, want %h %h busy=1 done=0",
                 tag, i, bad_e, hi, lo, mhi, mlo);
      end
      @(posedge clk); #1;
      checks++;
      if (hi !== eh[i] || lo !== el[i] || done !== 1'b1 || busy !== 1'b0 || div_zero !== 1'b0) begin
        failures++;
        $display("FAIL %s%0d_result: hi=%h lo=%h done=%b busy=%b dz=%b, want %h %h 1 0 0",
                 tag, i, hi, lo, done, busy, div_zero, eh[i], el[i]);
      end
      mhi = eh[i]; mlo = el[i];
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL %s%0d_done_pulse: done=%b, want 0", tag, i, done);
      end
    end
  endtask

  task automatic test_mult();
    logic [2:0]  o [3] = '{OP_MULT, OP_MULTU, OP_MULT};
    logic [31:0] a [3] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0};
    logic [31:0] b [3] = '{32'd3, 32'd3, 32'd0};
    logic [31:0] h [3] = '{32'hFFFFFFFF, 32'h00000002, 32'd0};
    logic [31:0] l [3] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'd0};
    test_long_ops("mul", o, a, b, h, l, 2);
  endtask

  task automatic test_div();
    logic [2:0]  o [3] = '{OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] a [3] = '{32'hFFFFFFF9, 32'd100, 32'h80000000};
    logic [31:0] b [3] = '{32'd2, 32'd7, 32'hFFFFFFFF};
    logic [31:0] h [3] = '{32'hFFFFFFFF, 32'h00000002, 32'h00000000};
    logic [31:0] l [3] = '{32'hFFFFFFFD, 32'h0000000E, 32'h80000000};
    test_long_ops("div", o, a, b, h, l, 3);
  endtask

  task automatic test_div_zero();
    drive_start(OP_DIVU, 32'd5, 32'd0);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_e0: busy=%b done=%b dz=%b, want 1 0 0", busy, done, div_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || div_zero !== 1'b1 || hi !== mhi || lo !== mlo) begin
      failures++;
      $display("FAIL dz_e1: busy=%b done=%b dz=%b hi=%h lo=%h, want 0 1 1 %h %h",
               busy, done, div_zero, hi, lo, mhi, mlo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL dz_pulse: done=%b dz=%b, want 0 0", done, div_zero);
    end
  endtask

  task automatic test_drop_and_abort();
    int seen_done;
    drive_start(OP_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (4) @(posedge clk);
    #1;
    drive_start(OP_MTLO, 32'hDEADBEEF, 32'd0);
    checks++;
    if (lo !== mlo || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_drop: lo=%h done=%b busy=%b, want %h 0 1", lo, done, busy, mlo);
    end
    repeat (4) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({hi, lo} !== 64'd0 || {busy, done, div_zero} !== 3'b000) begin
      failures++;
      $display("FAIL abort_reset: hi=%h lo=%h busy=%b done=%b dz=%b, want 0 0 0 0 0",
               hi, lo, busy, done, div_zero);
    end
    mhi = 32'd0; mlo = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    seen_done = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen_done = 1;
    end
    checks++;
    if (seen_done != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL abort_no_resume: activity=%0d hi=%h lo=%h, want 0 0 0", seen_done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(OP_MULT, 32'd7, 32'hFFFFFFFD);
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: hi=%h lo=%h done=%b busy=%b, want ffffffff ffffffeb 1 0",
               hi, lo, done, busy);
    end
    drive_start(OP_MULT, 32'h00010000, 32'h00010000);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      failures++;
      $display("FAIL b2b_launch: busy=%b done=%b hi=%h lo=%h, want 1 0 ffffffff ffffffeb",
               busy, done, hi, lo);
    end
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if (hi !== 32'h00000001 || lo !== 32'h00000000 || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: hi=%h lo=%h done=%b busy=%b, want 00000001 00000000 1 0",
               hi, lo, done, busy);
    end
  endtask

  initial begin
    mhi = 32'd0; mlo = 32'd0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_div_zero();
    test_drop_and_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
